gl_commit_ctrl: RTL and testbench

GL_COMMIT_CTRL -- requirements
Module: gl_commit_ctrl

---
 rtl/drac_pkg.sv | 48 ++++
 rtl/gl_commit_ctrl.sv | 121 ++++++++++++
 tb/tb_gl_commit_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/drac_pkg.sv
// Shared types for the graduation-list commit path: instruction/exception records,
// physical register ids and the commit FSM encoding.
package drac_pkg;

  typedef logic [63:0] bus64_t;
  typedef logic [5:0]  phreg_t;
  typedef logic [5:0]  gl_index_t;

  typedef enum logic [1:0] {
    NOT_MEM,
    LOAD,
    STORE,
    AMO
  } mem_type_t;

  // An all-zero entry means the graduation list has nothing ready in that slot.
  typedef struct packed {
    logic      valid;
    bus64_t    pc;
    mem_type_t mem_type;
    logic      is_csr;
    logic      ex_valid;
    logic      regfile_we;
    phreg_t    old_prd;
  } gl_instruction_t;

  typedef struct packed {
    logic [4:0] cause;
    bus64_t     origin;
    logic       valid;
  } exception_t;

  typedef enum logic [1:0] {
    RUN,
    WAIT_STORE,
    WAIT_CSR,
    FLUSH
  } commit_state_t;

  localparam logic [1:0] READ_HEAD_NONE = 2'b00;
  localparam logic [1:0] READ_HEAD_ONE  = 2'b01;
  localparam logic [1:0] READ_HEAD_TWO  = 2'b11;

  function automatic logic is_mem_commit(input gl_instruction_t ins);
    return (ins.mem_type == STORE) || (ins.mem_type == AMO);
  endfunction

endpackage

// File: rtl/gl_commit_ctrl.sv
// Commit controller: retires up to two graduation-list head entries per cycle and
// sequences stores/AMOs, CSRs and exceptions through the LSU, CSR unit and flush.
module gl_commit_ctrl
  import drac_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  gl_instruction_t [1:0] instruction_i,
  input  gl_index_t             commit_gl_entry_i,
  input  exception_t            exception_i,
  output logic [1:0]            read_head_o,
  output logic                  store_commit_o,
  input  logic                  store_ack_i,
  output logic                  csr_req_o,
  input  logic                  csr_ack_i,
  input  logic                  csr_flush_i,
  output logic [1:0]            free_valid_o,
  output phreg_t [1:0]          free_preg_o,
  output logic                  flush_commit_o,
  output exception_t            xcpt_o,
  output bus64_t                xcpt_pc_o,
  input  logic                  commit_stall_i,
  output logic [63:0]           instret_o,
  output commit_state_t         state_o
);

  // Handshakes: store_commit_o is a one-cycle request completed by store_ack_i;
  // csr_req_o stays high until the cycle csr_ack_i (with csr_flush_i) arrives.
  commit_state_t   state, next_state;
  logic [63:0]     instret;
  logic [1:0]      read_head;
  logic [1:0]      retire_cnt;
  logic            store_commit, csr_req, flush, take_xcpt;
  logic            slot1_plain;
  gl_instruction_t slot0, slot1;

  assign slot0 = instruction_i[0];
  assign slot1 = instruction_i[1];
  assign slot1_plain = slot1.valid && !slot1.ex_valid && !is_mem_commit(slot1) && !slot1.is_csr;

  // The head index and slot-1 pc carry no information the commit decision needs.
  logic unused_ok;
  assign unused_ok = ^{commit_gl_entry_i, slot1.pc};

  always_comb begin
    next_state   = state;
    read_head    = READ_HEAD_NONE;
    store_commit = 1'b0;
    csr_req      = 1'b0;
    flush        = 1'b0;
    take_xcpt    = 1'b0;
    case (state)
      RUN: begin
        if (!commit_stall_i && slot0.valid) begin
          if (slot0.ex_valid) begin
            if (exception_i.valid) begin
              flush      = 1'b1;
              take_xcpt  = 1'b1;
              next_state = FLUSH;
            end
          end else if (is_mem_commit(slot0)) begin
            store_commit = 1'b1;
            next_state   = WAIT_STORE;
          end else if (slot0.is_csr) begin
            csr_req    = 1'b1;
            next_state = WAIT_CSR;
          end else begin
            read_head = slot1_plain ? READ_HEAD_TWO : READ_HEAD_ONE;
          end
        end
      end
      WAIT_STORE: begin
        if (store_ack_i) begin
          read_head  = READ_HEAD_ONE;
          next_state = RUN;
        end
      end
      WAIT_CSR: begin
        csr_req = 1'b1;
        if (csr_ack_i) begin
          read_head = READ_HEAD_ONE;
          if (csr_flush_i) begin
            flush      = 1'b1;
            next_state = FLUSH;
          end else begin
            next_state = RUN;
          end
        end
      end
      FLUSH:   next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  assign retire_cnt = {1'b0, read_head[0]} + {1'b0, read_head[1]};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= RUN;
      instret <= '0;
    end else begin
      state   <= next_state;
      instret <= instret + {62'd0, retire_cnt};
    end
  end

  // Decisions are combinational on the head entries, so they are masked while in reset.
  assign read_head_o     = rstn_i ? read_head : READ_HEAD_NONE;
  assign store_commit_o  = rstn_i && store_commit;
  assign csr_req_o       = rstn_i && csr_req;
  assign flush_commit_o  = rstn_i && flush;
  assign free_valid_o[0] = rstn_i && read_head[0] && slot0.regfile_we;
  assign free_valid_o[1] = rstn_i && read_head[1] && slot1.regfile_we;
  assign free_preg_o[0]  = free_valid_o[0] ? slot0.old_prd : '0;
  assign free_preg_o[1]  = free_valid_o[1] ? slot1.old_prd : '0;
  assign xcpt_o          = (rstn_i && take_xcpt) ? exception_i : '0;
  assign xcpt_pc_o       = (rstn_i && take_xcpt) ? slot0.pc : '0;
  assign instret_o       = instret;
  assign state_o         = state;

endmodule

// File: tb/tb_gl_commit_ctrl.sv
// Bench for gl_commit_ctrl: a graduation-list queue model predicts every cycle's
// outputs; a negedge monitor compares them, plus directed scenario checks.
module tb_gl_commit_ctrl;
  import drac_pkg::*;

  logic                  clk = 1'b0;
  logic                  rstn;
  gl_instruction_t [1:0] instruction;
  gl_index_t             commit_gl_entry;
  exception_t            exception;
  logic [1:0]            read_head;
  logic                  store_commit, store_ack, csr_req, csr_ack, csr_flush;
  logic [1:0]            free_valid;
  phreg_t [1:0]          free_preg;
  logic                  flush_commit;
  exception_t            xcpt;
  bus64_t                xcpt_pc;
  logic                  commit_stall;
  logic [63:0]           instret;
  commit_state_t         state;

  gl_commit_ctrl dut (
    .clk_i(clk), .rstn_i(rstn), .instruction_i(instruction),
    .commit_gl_entry_i(commit_gl_entry), .exception_i(exception),
    .read_head_o(read_head), .store_commit_o(store_commit), .store_ack_i(store_ack),
    .csr_req_o(csr_req), .csr_ack_i(csr_ack), .csr_flush_i(csr_flush),
    .free_valid_o(free_valid), .free_preg_o(free_preg), .flush_commit_o(flush_commit),
    .xcpt_o(xcpt), .xcpt_pc_o(xcpt_pc), .commit_stall_i(commit_stall),
    .instret_o(instret), .state_o(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    read_head;
    logic          store_commit;
    logic          csr_req;
    logic [1:0]    free_valid;
    phreg_t [1:0]  free_preg;
    logic          flush;
    exception_t    xcpt;
    bus64_t        xcpt_pc;
    logic [63:0]   instret;
    commit_state_t state;
  } obs_t;
  localparam int OW = $bits(obs_t);

  typedef struct packed {
    gl_instruction_t ins;
    logic [4:0]      cause;
  } entry_t;

  logic [OW-1:0] exp_q[$];
  entry_t        gl_q[$];
  int            checks = 0;
  int            errors = 0;
  commit_state_t mode;
  logic [63:0]   ref_cnt;
  gl_index_t     head_idx;
  bit            auto_fill;
  logic [63:0]   saved_cnt;

  // kinds: 0 plain, 1 store, 2 amo, 3 csr, 4 exception
  function automatic entry_t mk(input int kind, input int prd, input logic we,
                                input logic [63:0] pc, input int cause);
    entry_t e;
    e = '0;
    e.ins.valid      = 1'b1;
    e.ins.pc         = pc;
    e.ins.regfile_we = we;
    e.ins.old_prd    = phreg_t'(prd);
    case (kind)
      1: e.ins.mem_type = STORE;
      2: e.ins.mem_type = AMO;
      3: e.ins.is_csr = 1'b1;
      4: begin
        e.ins.ex_valid = 1'b1;
        e.cause = 5'(cause);
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic entry_t rand_entry();
    int k;
    int kind;
    entry_t e;
    k = $urandom_range(0, 99);
    kind = (k < 55) ? 0 : (k < 67) ? 1 : (k < 72) ? 2 : (k < 84) ? 3 : 4;
    e = mk(kind, $urandom_range(0, 63), 1'($urandom_range(0, 1)),
           64'h8000_0000 + 64'($urandom_range(0, 4095)) * 4, $urandom_range(0, 15));
    if (kind == 0 && $urandom_range(0, 1) == 1) e.ins.mem_type = LOAD;
    return e;
  endfunction

  function automatic bit plain(input gl_instruction_t i);
    return i.valid && !i.ex_valid && i.mem_type != STORE && i.mem_type != AMO && !i.is_csr;
  endfunction

  // driver + reference model: one call is one clock cycle
  task automatic step(input bit rst, input bit stall, input bit sack, input bit cack,
                      input bit cflush, input bit hide);
    obs_t       e;
    entry_t     h0, h1;
    exception_t ex;
    int         n;
    bit         wipe;
    @(posedge clk);
    #1;
    if (auto_fill) while (gl_q.size() < 4) gl_q.push_back(rand_entry());
    if (mode != RUN) hide = 1'b0;
    h0 = '0;
    h1 = '0;
    if (!hide && gl_q.size() > 0) h0 = gl_q[0];
    if (!hide && gl_q.size() > 1) h1 = gl_q[1];
    ex = '0;
    foreach (gl_q[i]) begin
      if (gl_q[i].ins.ex_valid && !ex.valid) begin
        ex.valid  = 1'b1;
        ex.cause  = gl_q[i].cause;
        ex.origin = gl_q[i].ins.pc;
      end
    end
    rstn            = !rst;
    commit_stall    = stall;
    store_ack       = sack;
    csr_ack         = cack;
    csr_flush       = cflush;
    instruction[0]  = h0.ins;
    instruction[1]  = h1.ins;
    exception       = ex;
    commit_gl_entry = head_idx;
    e = '0;
    n = 0;
    wipe = 1'b0;
    if (rst) begin
      mode    = RUN;
      ref_cnt = '0;
    end else begin
      e.instret = ref_cnt;
      e.state   = mode;
      case (mode)
        RUN: begin
          if (!stall && h0.ins.valid) begin
            if (h0.ins.ex_valid) begin
              if (ex.valid) begin
                e.flush   = 1'b1;
                e.xcpt    = ex;
                e.xcpt_pc = h0.ins.pc;
                wipe      = 1'b1;
                mode      = FLUSH;
              end
            end else if (h0.ins.mem_type == STORE || h0.ins.mem_type == AMO) begin
              e.store_commit = 1'b1;
              mode = WAIT_STORE;
            end else if (h0.ins.is_csr) begin
              e.csr_req = 1'b1;
              mode = WAIT_CSR;
            end else begin
              n = plain(h1.ins) ? 2 : 1;
            end
          end
        end
        WAIT_STORE: if (sack) begin
          n = 1;
          mode = RUN;
        end
        WAIT_CSR: begin
          e.csr_req = 1'b1;
          if (cack) begin
            n = 1;
            e.flush = cflush;
            wipe = cflush;
            mode = cflush ? FLUSH : RUN;
          end
        end
        default: mode = RUN;
      endcase
      if (n >= 1) begin
        e.read_head = (n == 2) ? 2'b11 : 2'b01;
        if (h0.ins.regfile_we) begin
          e.free_valid[0] = 1'b1;
          e.free_preg[0]  = h0.ins.old_prd;
        end
      end
      if (n == 2 && h1.ins.regfile_we) begin
        e.free_valid[1] = 1'b1;
        e.free_preg[1]  = h1.ins.old_prd;
      end
      for (int i = 0; i < n; i++) void'(gl_q.pop_front());
      head_idx = head_idx + gl_index_t'(n);
      ref_cnt  = ref_cnt + 64'(n);
      if (wipe) gl_q.delete();
    end
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  obs_t mon_exp, mon_act;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act.read_head    = read_head;
      mon_act.store_commit = store_commit;
      mon_act.csr_req      = csr_req;
      mon_act.free_valid   = free_valid;
      mon_act.free_preg    = free_preg;
      mon_act.flush        = flush_commit;
      mon_act.xcpt         = xcpt;
      mon_act.xcpt_pc      = xcpt_pc;
      mon_act.instret      = instret;
      mon_act.state        = state;
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL scoreboard t=%0t actual=%h expected=%h", $time, mon_act, mon_exp);
      end
    end
  end

  initial begin
    rstn = 1'b0;
    commit_stall = 1'b0;
    store_ack = 1'b0;
    csr_ack = 1'b0;
    csr_flush = 1'b0;
    instruction = '0;
    exception = '0;
    commit_gl_entry = '0;
    mode = RUN;
    ref_cnt = '0;
    head_idx = '0;
    auto_fill = 1'b0;

    // reset with two ready adds: nothing may leave the block
    gl_q.push_back(mk(0, 5, 1'b1, 64'h8000_0000, 0));
    gl_q.push_back(mk(0, 6, 1'b1, 64'h8000_0004, 0));
    step(1, 0, 0, 0, 0, 0);
    check("reset_read_head", 64'(read_head), 64'd0);
    check("reset_free_valid", 64'(free_valid), 64'd0);
    check("reset_instret", instret, 64'd0);
    check("reset_state", 64'(state), 64'(RUN));

    // dual retirement of two plain adds
    step(0, 0, 0, 0, 0, 0);
    check("dual_read_head", 64'(read_head), 64'b11);
    check("dual_free_preg", 64'(free_preg), 64'h185);
    check("dual_free_valid", 64'(free_valid), 64'b11);
    step(0, 0, 0, 0, 0, 0);
    check("dual_instret", instret, 64'd2);

    // plain then store: store waits for its ack three cycles later
    gl_q.push_back(mk(0, 7, 1'b1, 64'h8000_0008, 0));
    gl_q.push_back(mk(1, 0, 1'b0, 64'h8000_000c, 0));
    step(0, 0, 0, 0, 0, 0);
    check("store_pre_read_head", 64'(read_head), 64'b01);
    step(0, 0, 0, 0, 0, 0);
    check("store_commit_pulse", 64'(store_commit), 64'd1);
    check("store_commit_no_retire", 64'(read_head), 64'd0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("store_wait_hold", 64'({store_commit, read_head}), 64'd0);
    step(0, 0, 1, 0, 0, 0);
    check("store_ack_retire", 64'(read_head), 64'b01);
    step(0, 0, 0, 0, 0, 0);
    check("store_back_run", 64'(state), 64'(RUN));

    // CSR acked with flush after two waiting cycles
    gl_q.push_back(mk(3, 9, 1'b1, 64'h8000_0020, 0));
    step(0, 0, 0, 0, 0, 0);
    check("csr_req_issue", 64'(csr_req), 64'd1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("csr_req_held", 64'(csr_req), 64'd1);
    step(0, 0, 0, 1, 1, 0);
    check("csr_retire", 64'(read_head), 64'b01);
    check("csr_flush_pulse", 64'(flush_commit), 64'd1);
    step(0, 0, 0, 0, 0, 0);
    check("csr_in_flush", 64'(state), 64'(FLUSH));
    check("csr_flush_once", 64'(flush_commit), 64'd0);
    step(0, 0, 0, 0, 0, 0);
    check("csr_back_run", 64'(state), 64'(RUN));

    // illegal-instruction exception at the head
    gl_q.push_back(mk(4, 3, 1'b1, 64'h8000_0010, 2));
    gl_q.push_back(mk(0, 4, 1'b1, 64'h8000_0014, 0));
    saved_cnt = ref_cnt;
    step(0, 0, 0, 0, 0, 0);
    check("xcpt_read_head", 64'(read_head), 64'd0);
    check("xcpt_flush", 64'(flush_commit), 64'd1);
    check("xcpt_cause", 64'(xcpt.cause), 64'd2);
    check("xcpt_pc", xcpt_pc, 64'h8000_0010);
    step(0, 0, 0, 0, 0, 0);
    check("xcpt_instret", instret, saved_cnt);

    // debug stall holds two plain entries
    gl_q.push_back(mk(0, 10, 1'b1, 64'h8000_0040, 0));
    gl_q.push_back(mk(0, 11, 1'b0, 64'h8000_0044, 0));
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0, 0);
      check("stall_hold", 64'(read_head), 64'd0);
    end
    step(0, 0, 0, 0, 0, 0);
    check("stall_release", 64'(read_head), 64'b11);

    // reset in the middle of WAIT_STORE, then a late ack
    gl_q.push_back(mk(2, 12, 1'b1, 64'h8000_0050, 0));
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("midreset_pre_state", 64'(state), 64'(WAIT_STORE));
    step(1, 0, 0, 0, 0, 0);
    check("midreset_outputs", 64'({read_head, store_commit, csr_req, free_valid, flush_commit}), 64'd0);
    check("midreset_state", 64'(state), 64'(RUN));
    check("midreset_instret", instret, 64'd0);
    step(0, 0, 1, 0, 0, 0);
    check("late_ack_no_retire", 64'(read_head), 64'd0);
    step(0, 0, 1, 0, 0, 0);
    check("reissued_store_retire", 64'(read_head), 64'b01);

    // randomized traffic
    gl_q.delete();
    auto_fill = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    end
    step(0, 0, 0, 0, 0, 0);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
